octet_array: RTL and testbench

Parametrised tensor-core octet: `LANES` threadgroup lanes share one activation stream and each keep private weights and partial sums. The block loads A (weights), B (activations) and C (partial sums) tiles through valid/ready streams. It computes `C + A·B` in signed int8 with `ACC_W`-bit accumulation, then streams the result tile out under backpressure. It sits between the SM operand collector and the register-file write port, and is the generalised successor of the fixed two-threadgroup octet.

---
 rtl/octet_array.sv | 217 +++++++++++++++++++++
 tb/tb_octet_array.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/octet_array.sv
// Tensor-core octet: LANES lanes share a B (activation) stream, each holding private A and C rows.
// Build option OCTET_SAT_EN: saturate each lane's result to ACC_W bits instead of wrapping.

module octet_lane #(
  parameter int ELEMS = 4,
  parameter int ACC_W = 16
) (
  input  logic [ELEMS*8-1:0] a_i,
  input  logic [ELEMS*8-1:0] b_i,
  input  logic [ACC_W-1:0]   c_i,
  output logic [ACC_W-1:0]   c_o
);
  localparam int EW = $clog2(ELEMS);
  // One guard bit above the widest of the accumulator and the dot product.
  localparam int FW = ((ACC_W > 16 + EW) ? ACC_W : 16 + EW) + 1;

  logic signed [FW-1:0] acc;
  logic signed [15:0]   prod;

  always_comb begin
    acc  = FW'($signed(c_i));
    prod = '0;
    for (int e = 0; e < ELEMS; e++) begin
      prod = 16'(signed'(a_i[e*8 +: 8])) * 16'(signed'(b_i[e*8 +: 8]));
      acc  = acc + FW'(prod);
    end
  end

`ifdef OCTET_SAT_EN
  localparam logic signed [FW-1:0] MAXV = {{(FW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [FW-1:0] MINV = {{(FW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  always_comb begin
    if (acc > MAXV)      c_o = MAXV[ACC_W-1:0];
    else if (acc < MINV) c_o = MINV[ACC_W-1:0];
    else                 c_o = acc[ACC_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^acc[FW-1:ACC_W];
  assign c_o       = acc[ACC_W-1:0];
`endif
endmodule

module octet_array #(
  parameter int LANES   = 2,
  parameter int ELEMS   = 4,
  parameter int ACC_W   = 16,
  parameter int A_DEPTH = 2,
  parameter int B_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     a_valid_i,
  output logic                     a_ready_o,
  input  logic [LANES*ELEMS*8-1:0] a_data_i,
  input  logic                     b_valid_i,
  output logic                     b_ready_o,
  input  logic [ELEMS*8-1:0]       b_data_i,
  input  logic                     c_valid_i,
  output logic                     c_ready_o,
  input  logic [LANES*ACC_W-1:0]   c_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES*ACC_W-1:0]   out_data_o,
  output logic                     out_last_o,
  output logic                     idle_o,
  output logic                     fetch_o,
  output logic                     compute_o,
  output logic                     write_back_o,
  output logic                     done_o
);
  localparam int C_DEPTH = A_DEPTH * B_DEPTH;
  localparam int AW  = $clog2(A_DEPTH + 1);
  localparam int BW  = $clog2(B_DEPTH + 1);
  localparam int CW  = $clog2(C_DEPTH + 1);
  localparam int RAW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int RBW = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int RCW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

  localparam logic [AW-1:0]  A_FULL  = AW'(A_DEPTH);
  localparam logic [BW-1:0]  B_FULL  = BW'(B_DEPTH);
  localparam logic [CW-1:0]  C_FULL  = CW'(C_DEPTH);
  localparam logic [RBW-1:0] RB_LAST = RBW'(B_DEPTH - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(C_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMPUTE, S_WB} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  a_cnt_q, a_cnt_d;
  logic [BW-1:0]  b_cnt_q, b_cnt_d;
  logic [CW-1:0]  c_cnt_q, c_cnt_d;
  logic [RCW-1:0] ci_q, ci_d;
  logic [RAW-1:0] ra_q, ra_d;
  logic [RBW-1:0] rb_q, rb_d;
  logic [RCW-1:0] r_q, r_d;
  logic           done_q, done_d;

  // Operand storage, deliberately not reset.
  logic [A_DEPTH-1:0][LANES-1:0][ELEMS*8-1:0] a_buf_q;
  logic [B_DEPTH-1:0][ELEMS*8-1:0]            b_buf_q;
  logic [C_DEPTH-1:0][LANES-1:0][ACC_W-1:0]   c_buf_q;
  logic [LANES-1:0][ACC_W-1:0]                lane_res;

  logic a_hs, b_hs, c_hs;

  assign a_ready_o = (state_q == S_FETCH) && (a_cnt_q != A_FULL);
  assign b_ready_o = (state_q == S_FETCH) && (b_cnt_q != B_FULL);
  assign c_ready_o = (state_q == S_FETCH) && (c_cnt_q != C_FULL);
  assign a_hs      = a_valid_i & a_ready_o;
  assign b_hs      = b_valid_i & b_ready_o;
  assign c_hs      = c_valid_i & c_ready_o;

  assign idle_o       = (state_q == S_IDLE);
  assign fetch_o      = (state_q == S_FETCH);
  assign compute_o    = (state_q == S_COMPUTE);
  assign write_back_o = (state_q == S_WB);
  assign out_valid_o  = write_back_o;
  assign out_data_o   = out_valid_o ? c_buf_q[r_q] : '0;
  assign out_last_o   = out_valid_o && (r_q == RC_LAST);
  assign done_o       = done_q;

  always_comb begin
    state_d = state_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    c_cnt_d = c_cnt_q;
    ci_d    = ci_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          a_cnt_d = '0;
          b_cnt_d = '0;
          c_cnt_d = '0;
          ci_d    = '0;
          ra_d    = '0;
          rb_d    = '0;
          r_d     = '0;
        end
      end
      S_FETCH: begin
        if (a_hs) a_cnt_d = a_cnt_q + 1'b1;
        if (b_hs) b_cnt_d = b_cnt_q + 1'b1;
        if (c_hs) c_cnt_d = c_cnt_q + 1'b1;
        // Looks at next-state counts so COMPUTE follows the final beat directly.
        if (a_cnt_d == A_FULL && b_cnt_d == B_FULL && c_cnt_d == C_FULL)
          state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        ci_d = ci_q + 1'b1;
        if (rb_q == RB_LAST) begin
          rb_d = '0;
          ra_d = ra_q + 1'b1;
        end else begin
          rb_d = rb_q + 1'b1;
        end
        if (ci_q == RC_LAST) state_d = S_WB;
      end
      S_WB: begin
        if (out_ready_i) begin
          r_d = r_q + 1'b1;
          if (r_q == RC_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
      ci_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      c_cnt_q <= c_cnt_d;
      ci_q    <= ci_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (a_hs) a_buf_q[a_cnt_q[RAW-1:0]] <= a_data_i;
    if (b_hs) b_buf_q[b_cnt_q[RBW-1:0]] <= b_data_i;
    if (c_hs)                         c_buf_q[c_cnt_q[RCW-1:0]] <= c_data_i;
    else if (state_q == S_COMPUTE)    c_buf_q[ci_q]             <= lane_res;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    octet_lane #(.ELEMS(ELEMS), .ACC_W(ACC_W)) u_lane (
      .a_i (a_buf_q[ra_q][l]),
      .b_i (b_buf_q[rb_q]),
      .c_i (c_buf_q[ci_q][l]),
      .c_o (lane_res[l])
    );
  end
endmodule

// File: tb/tb_octet_array.sv
// Directed bench for octet_array: uniform and patterned tiles, skew, backpressure, reset/start.
module tb_octet_array;
  localparam int LANES = 2, ELEMS = 4, ACC_W = 16, A_DEPTH = 2, B_DEPTH = 4;
  localparam int C_DEPTH = A_DEPTH * B_DEPTH;
  localparam int AD = LANES*ELEMS*8, BD = ELEMS*8, CD = LANES*ACC_W;

  logic          clk = 1'b0, rst, start;
  logic          a_valid, a_ready, b_valid, b_ready, c_valid, c_ready;
  logic [AD-1:0] a_data;
  logic [BD-1:0] b_data;
  logic [CD-1:0] c_data, out_data;
  logic          out_valid, out_ready, out_last;
  logic          idle, fetch, compute, write_back, done;

  octet_array #(.LANES(LANES), .ELEMS(ELEMS), .ACC_W(ACC_W), .A_DEPTH(A_DEPTH), .B_DEPTH(B_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
    .c_valid_i(c_valid), .c_ready_o(c_ready), .c_data_i(c_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .idle_o(idle), .fetch_o(fetch), .compute_o(compute), .write_back_o(write_back), .done_o(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic        pat;
  logic [7:0]  av, bv;
  logic [15:0] cv, exp_u;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Patterned tiles: A[a][l][e]=a+1+l, B[b][e]=b+1, C[i][l]=i*256+l*16+3.
  function automatic logic [AD-1:0] a_row(input int r);
    logic [AD-1:0] d;
    for (int l = 0; l < LANES; l++)
      for (int e = 0; e < ELEMS; e++) d[(l*ELEMS+e)*8 +: 8] = pat ? 8'(r + 1 + l) : av;
    return d;
  endfunction

  function automatic logic [BD-1:0] b_row(input int r);
    logic [BD-1:0] d;
    for (int e = 0; e < ELEMS; e++) d[e*8 +: 8] = pat ? 8'(r + 1) : bv;
    return d;
  endfunction

  function automatic logic [CD-1:0] c_row(input int i);
    logic [CD-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*ACC_W +: ACC_W] = pat ? 16'(i*256 + l*16 + 3) : cv;
    return d;
  endfunction

  function automatic logic [CD-1:0] exp_row(input int i);
    logic [CD-1:0] d;
    int a, b;
    a = i / B_DEPTH;
    b = i % B_DEPTH;
    for (int l = 0; l < LANES; l++)
      d[l*ACC_W +: ACC_W] = pat ? 16'(i*256 + l*16 + 3 + ELEMS*(a+1+l)*(b+1)) : exp_u;
    return d;
  endfunction

  // Entered at a negedge in IDLE; returns at the first COMPUTE negedge.
  task automatic load_tile(input int cdelay, output bit ok);
    int acnt = 0, bcnt = 0, ccnt = 0, wt = 0, guard = 0;
    bit ha, hb, hc, prev_hc = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fetch_after_start", fetch, 1);
    chk("a_ready_on_entry", a_ready, 1);
    chk("b_ready_on_entry", b_ready, 1);
    while (!compute && guard < 64) begin
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = a_row(acnt < A_DEPTH ? acnt : 0);
      b_data  = b_row(bcnt < B_DEPTH ? bcnt : 0);
      if (acnt == A_DEPTH && bcnt == B_DEPTH) begin
        if (ccnt < C_DEPTH) begin
          chk("a_ready_after_full", a_ready, 0);
          chk("b_ready_after_full", b_ready, 0);
        end
        wt++;
      end
      c_valid = (cdelay == 0) || (wt > cdelay);
      c_data  = c_row(ccnt < C_DEPTH ? ccnt : 0);
      ha = a_valid & a_ready;
      hb = b_valid & b_ready;
      hc = c_valid & c_ready;
      @(negedge clk);
      guard++;
      acnt += int'(ha);
      bcnt += int'(hb);
      ccnt += int'(hc);
      prev_hc = hc;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    c_valid = 1'b0;
    ok = compute;
    chk("fetch_to_compute", compute, 1);
    chk("beats_a", acnt, A_DEPTH);
    chk("beats_b", bcnt, B_DEPTH);
    chk("beats_c", ccnt, C_DEPTH);
    chk("compute_after_last_c", prev_hc, 1);
  endtask

  // Entered at the first COMPUTE negedge; returns at the done negedge.
  task automatic finish_tile(input bit bp, input bit start_in_wb);
    int ccyc = 0, r = 0, guard = 0, hs_n = 0;
    bit hs, tog = 1'b0;
    while (compute && guard < 64) begin
      chk("out_valid_in_compute", out_valid, 0);
      @(negedge clk);
      ccyc++;
      guard++;
    end
    chk("compute_len", ccyc, C_DEPTH);
    chk("wb_entry", write_back, 1);
    guard = 0;
    while (r < C_DEPTH && guard < 64) begin
      out_ready = bp ? tog : 1'b1;
      tog       = ~tog;
      start     = start_in_wb && (guard == 1);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp_row(r));
      chk("out_last", out_last, r == C_DEPTH - 1);
      chk("done_early", done, 0);
      hs = out_valid & out_ready;
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (hs) begin
        r++;
        hs_n++;
      end
    end
    out_ready = 1'b0;
    chk("handshakes", hs_n, C_DEPTH);
    chk("done_pulse", done, 1);
    chk("idle_with_done", idle, 1);
    chk("out_data_idle", out_data, 0);
  endtask

  task automatic run_tile(input int cdelay, input bit bp, input bit start_in_wb);
    bit ok;
    load_tile(cdelay, ok);
    if (ok) finish_tile(bp, start_in_wb);
  endtask

  initial begin
    int k0;
    bit ok;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    pat = 1'b0; av = '0; bv = '0; cv = '0; exp_u = '0;
    repeat (2) @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_flags", {fetch, compute, write_back, done}, 0);
    chk("rst_out", {out_valid, out_last}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_readys", {a_ready, b_ready, c_ready}, 0);
    rst = 1'b0;
    a_valid = 1'b1;
    @(negedge clk);
    chk("valid_in_idle", {idle, a_ready}, 2'b10);
    a_valid = 1'b0;

    // Basic: 5 + 4*(1*2) = 13 per lane, plus latency.
    av = 8'd1; bv = 8'd2; cv = 16'h0005; exp_u = 16'h000D;
    k0 = cyc;
    run_tile(0, 1'b0, 1'b0);
    chk("latency", cyc - k0, 1 + C_DEPTH + C_DEPTH + C_DEPTH);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Signed: 10 + 4*(-3*7) = -74.
    av = 8'hFD; bv = 8'd7; cv = 16'd10; exp_u = 16'hFFB6;
    run_tile(0, 1'b0, 1'b0);
    @(negedge clk);

    // Overflow: 0x7F00 + 4*127*127 exceeds the positive range.
    av = 8'd127; bv = 8'd127; cv = 16'h7F00;
`ifdef OCTET_SAT_EN
    exp_u = 16'h7FFF;
`else
    exp_u = 16'(32'h7F00 + 4*127*127);
`endif
    run_tile(0, 1'b0, 1'b0);
    @(negedge clk);

    // Skewed C stream, patterned data checks row ordering.
    pat = 1'b1;
    run_tile(5, 1'b0, 1'b0);
    @(negedge clk);

    // Backpressure with an ignored start in WRITEBACK, then start in the done cycle.
    run_tile(0, 1'b1, 1'b1);
    pat = 1'b0; av = 8'd1; bv = 8'd2; cv = 16'h0005; exp_u = 16'h000D;
    run_tile(0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset mid-COMPUTE aborts the tile.
    load_tile(0, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_idle", idle, 1);
    chk("rst_mid_flags", {compute, write_back, out_valid, done}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
